// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with programmable wait states.
// Optional macro DMEM_PERF_CNT_EN adds load/store/error access counters.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | counting down wait states before the access
// RESP  | holding the response until rsp_ready
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_errs
`endif
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  logic            accept, do_access, err;
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [XLEN-1:0] acc_addr, acc_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]      off;
  logic [XLEN-1:0] mem [2**DEPTH_LOG2];
  logic [XLEN-1:0] rd_word, wr_word, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge, so it
  // must see the live request rather than the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign idx     = acc_addr[DEPTH_LOG2+1:2];
  assign off     = acc_addr[1:0];
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];

  always_comb begin
    err = 1'b0;
    if ((acc_addr >> (DEPTH_LOG2 + 2)) != '0) err = 1'b1;
    case (acc_f3)
      3'b000:  ;
      3'b001:  if (off[0]) err = 1'b1;
      3'b010:  if (off != 2'b00) err = 1'b1;
      3'b100:  if (acc_we) err = 1'b1;
      3'b101:  if (acc_we || off[0]) err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (acc_f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    case (acc_f3)
      3'b000:  wr_word[{off, 3'b000} +: 8]     = acc_wdata[7:0];
      3'b001:  wr_word[{off[1], 4'b0000} +: 16] = acc_wdata[15:0];
      3'b010:  wr_word = acc_wdata;
      default: wr_word = rd_word;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (do_access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || acc_we) ? '0 : ld_data;
      end
    end
  end

  // Array is not reset; reset only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !err && !reset) mem[idx] <= wr_word;
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (do_access) begin
      if (err)         perf_errs   <= perf_errs + 32'd1;
      else if (acc_we) perf_stores <= perf_stores + 32'd1;
      else             perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the CPU MEM-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake and holds it for WAIT_CYCLES programmable wait states.
- Performs byte/half/word access on an internal word array and returns load data, sign- or zero-extended, over a valid/ready response channel.
- Used as the multi-cycle data memory behind the pipeline's stall logic.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_LOG2, 10, log2 of word count; the array holds 2^DEPTH_LOG2 words.
- WAIT_CYCLES, 2, wait states between accept and access; 0 is legal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  XLEN  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request faulted.
- busy  out  1  state!=IDLE.

Behaviour:
- Clock, reset and sequencing:
  - Single clock domain: clk. Reset is asynchronous, active-high: reset.
  - Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. req_ready=1 once in IDLE.
  - Array contents are not reset.
  - FSM states: IDLE, WAIT, RESP.
  - IDLE: on req_valid&&req_ready, capture we/funct3/addr/wdata.
    - WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
    - WAIT_CYCLES=0: perform the access at this same edge and go to RESP.
  - WAIT: decrement the counter each cycle. At counter==0, perform the access at that edge and go to RESP.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err stable, until an edge with rsp_ready=1. Then return to IDLE and clear rsp_valid.
  - A new request can be accepted only in IDLE, so there is no request/response overlap.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge. Minimum back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2]; byte offset = addr[1:0].
- Error conditions (set rsp_err=1, rsp_rdata=0, no array write):
  - addr[XLEN-1:DEPTH_LOG2+2] nonzero (out of range);
  - funct3 001/101 with addr[0]=1;
  - funct3 010 with addr[1:0]!=0;
  - funct3 011, 110 or 111;
  - store with funct3 100 or 101.
- Loads:
  - B: sign-extend the selected byte. BU: zero-extend it.
  - H: sign-extend the selected halfword (offset 0 or 2). HU: zero-extend it.
  - W: whole word.
- Stores:
  - Byte-lane write of wdata[7:0] or wdata[15:0] into the lane selected by the offset, or the full word.
  - Other lanes are unchanged.
- Reset asserted mid-operation (WAIT or RESP):
  - Immediate return to IDLE; rsp_valid drops asynchronously.
  - An access not yet performed is discarded; a store already performed remains.
- rsp_ready held high in IDLE/WAIT has no effect.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined: adds outputs perf_loads, perf_stores, perf_errs, each 32 bits.
  - All three reset to 0.
  - At the access edge, increment perf_errs on a faulted request, otherwise perf_loads or perf_stores. Faulted requests increment no other counter.
  - Counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Latency: WAIT_CYCLES=2; SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> each rsp_valid 3 edges after accept; load rdata=0xDEADBEEF, err=0.
- Loads after the store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- Store lanes: SB 0x11 wdata 0x12345677, then LW 0x10 -> 0xDEAD77EF. SH 0x12 wdata 0x0000CAFE, then LW 0x10 -> 0xCAFE77EF.
- Faults: LW 0x12 -> err=1, rdata=0. SH 0x13 -> err=1, and a following LW 0x10 is unchanged. LW 0x1000 with DEPTH_LOG2=10 -> err=1. SW funct3=100 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0. Raising rsp_ready -> IDLE on the next edge. WAIT_CYCLES=0 -> rsp_valid 1 edge after accept.
- Reset and counters: assert reset in WAIT during SW 0x20 wdata 5, release, then LW 0x20 -> old value; FSM is IDLE right after reset. With DMEM_PERF_CNT_EN and 3 loads, 2 stores, 1 fault -> perf_loads=3, perf_stores=2, perf_errs=1.
